// File: rtl/tage_pkg.sv
// Shared TAGE predictor types and helpers: base-table defaults, FSM states and the
// saturating-counter update used by every table.
package tage_pkg;

  parameter int unsigned BHT_IDX_W = 10;
  parameter int unsigned BHT_CTR_W = 2;
  // Widest counter any table may use; the helper works at this width plus one.
  parameter int unsigned CTR_MAX_W = 4;

  typedef logic [BHT_CTR_W-1:0] bht_ctr_t;

  typedef enum logic [0:0] {
    BHT_INIT,
    BHT_READY
  } bht_state_e;

  // Counter of ctr_w bits moved one step towards the outcome, clamped at 0 and 2**ctr_w-1.
  function automatic logic [CTR_MAX_W-1:0] sat_ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                        input logic taken,
                                                        input int unsigned ctr_w);
    logic [CTR_MAX_W:0] wide;
    logic [CTR_MAX_W:0] max_v;
    max_v = (CTR_MAX_W+1)'((1 << ctr_w) - 1);
    if (taken) begin
      wide = {1'b0, ctr} + (CTR_MAX_W+1)'(1);
      if (wide > max_v) wide = max_v;
    end else begin
      wide = {1'b0, ctr} - (CTR_MAX_W+1)'(1);
      if (wide[CTR_MAX_W]) wide = '0;
    end
    return wide[CTR_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/bht_init_seq.sv
// Post-reset sweep for the bimodal table: writes every entry once, then reports ready.
module bht_init_seq
  import tage_pkg::*;
#(
  parameter int unsigned IDX_W = BHT_IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             init_we_o,
  output logic [IDX_W-1:0] init_idx_o,
  output logic             ready_o
);

  localparam logic [IDX_W-1:0] LastIdx = '1;

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BHT_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    init_we_o = 1'b0;
    unique case (state_q)
      BHT_INIT: begin
        init_we_o = 1'b1;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LastIdx) state_d = BHT_READY;
      end
      BHT_READY: ;
    endcase
  end

  assign init_idx_o = ptr_q;
  assign ready_o    = (state_q == BHT_READY);

endmodule

// File: rtl/bht_param.sv
// Bimodal base predictor table: saturating counters with registered predict, single-port
// update with same-cycle forwarding, and a post-reset clear sweep instead of array reset.
module bht_param
  import tage_pkg::*;
#(
  parameter int unsigned     IDX_W    = BHT_IDX_W,
  parameter int unsigned     CTR_W    = BHT_CTR_W,
  parameter logic [CTR_W-1:0] INIT_VAL = CTR_W'((1 << (CTR_W - 1)) - 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             ready_o,
  input  logic             pred_req_i,
  input  logic [IDX_W-1:0] pred_idx_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic             pred_strong_o,
  output logic [CTR_W-1:0] pred_ctr_o,
  input  logic             upd_en_i,
  input  logic             upd_alloc_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CtrMax = '1;

  logic             init_we;
  logic [IDX_W-1:0] init_idx;
  logic             ready;

  bht_init_seq #(
    .IDX_W(IDX_W)
  ) u_init_seq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .init_we_o (init_we),
    .init_idx_o(init_idx),
    .ready_o   (ready)
  );

  logic [CTR_W-1:0] mem_q [DEPTH];

  logic             upd_eff;
  logic [CTR_W-1:0] upd_next;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;
  logic             pred_acc;
  logic [CTR_W-1:0] pred_ctr_d;

  always_comb begin
    upd_eff  = ready && (upd_en_i || upd_alloc_i);
    upd_next = upd_alloc_i ? INIT_VAL
             : CTR_W'(sat_ctr_next(CTR_MAX_W'(mem_q[upd_idx_i]), upd_taken_i, CTR_W));
    // The init sweep and updates never overlap: updates are only honoured once ready.
    wr_en    = init_we || upd_eff;
    wr_idx   = init_we ? init_idx : upd_idx_i;
    wr_data  = init_we ? INIT_VAL : upd_next;
    pred_acc = ready && pred_req_i;
    pred_ctr_d = (upd_eff && (pred_idx_i == upd_idx_i)) ? upd_next : mem_q[pred_idx_i];
  end

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic             pred_strong_q;
  logic [CTR_W-1:0] pred_ctr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_strong_q <= 1'b0;
      pred_ctr_q    <= '0;
    end else begin
      pred_valid_q <= pred_acc;
      if (pred_acc) begin
        pred_ctr_q    <= pred_ctr_d;
        pred_taken_q  <= pred_ctr_d[CTR_W-1];
        pred_strong_q <= (pred_ctr_d == '0) || (pred_ctr_d == CtrMax);
      end
    end
  end

  assign ready_o       = ready;
  assign pred_valid_o  = pred_valid_q;
  assign pred_taken_o  = pred_taken_q;
  assign pred_strong_o = pred_strong_q;
  assign pred_ctr_o    = pred_ctr_q;

endmodule

// File: tb/tb_bht_param.sv
// Directed self-checking bench for bht_param: a 16-entry 2-bit table and a 3-bit twin.
module tb_bht_param;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic       ready;
  logic       pred_req = 1'b0;
  logic [3:0] pred_idx = '0;
  logic       pred_valid, pred_taken, pred_strong;
  logic [1:0] pred_ctr;
  logic       upd_en = 1'b0, upd_alloc = 1'b0, upd_taken = 1'b0;
  logic [3:0] upd_idx = '0;

  logic       ready3;
  logic       pred_req3 = 1'b0;
  logic [3:0] pred_idx3 = '0;
  logic       pred_valid3, pred_taken3, pred_strong3;
  logic [2:0] pred_ctr3;
  logic       upd_en3 = 1'b0, upd_taken3 = 1'b0;
  logic [3:0] upd_idx3 = '0;

  int checks = 0;
  int errors = 0;

  bht_param #(.IDX_W(4), .CTR_W(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .ready_o(ready),
    .pred_req_i(pred_req), .pred_idx_i(pred_idx), .pred_valid_o(pred_valid),
    .pred_taken_o(pred_taken), .pred_strong_o(pred_strong), .pred_ctr_o(pred_ctr),
    .upd_en_i(upd_en), .upd_alloc_i(upd_alloc), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken)
  );

  bht_param #(.IDX_W(4), .CTR_W(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .ready_o(ready3),
    .pred_req_i(pred_req3), .pred_idx_i(pred_idx3), .pred_valid_o(pred_valid3),
    .pred_taken_o(pred_taken3), .pred_strong_o(pred_strong3), .pred_ctr_o(pred_ctr3),
    .upd_en_i(upd_en3), .upd_alloc_i(1'b0), .upd_idx_i(upd_idx3), .upd_taken_i(upd_taken3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pred(input logic [3:0] idx);
    pred_req = 1'b1; pred_idx = idx;
    step();
    pred_req = 1'b0;
  endtask

  task automatic upd(input logic [3:0] idx, input logic tk, input logic al);
    upd_en = 1'b1; upd_alloc = al; upd_idx = idx; upd_taken = tk;
    step();
    upd_en = 1'b0; upd_alloc = 1'b0;
  endtask

  task automatic pred3(input logic [3:0] idx);
    pred_req3 = 1'b1; pred_idx3 = idx;
    step();
    pred_req3 = 1'b0;
  endtask

  task automatic upd3(input logic [3:0] idx, input logic tk);
    upd_en3 = 1'b1; upd_idx3 = idx; upd_taken3 = tk;
    step();
    upd_en3 = 1'b0;
  endtask

  task automatic test_reset();
    int low;
    #12;
    checks++;
    if ({ready, pred_valid, pred_taken, pred_strong, pred_ctr} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000000",
               {ready, pred_valid, pred_taken, pred_strong, pred_ctr});
    end
    pred_req = 1'b1; pred_idx = 4'd0;
    step();
    rst_ni = 1'b1;
    low = 0;
    for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
      if (pred_valid !== 1'b0) low = 100;
      low++;
      step();
    end
    checks++;
    if (low !== 16) begin
      errors++; $display("FAIL init_length got %0d want 16", low);
    end
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++; $display("FAIL valid_at_ready got %b want 0", pred_valid);
    end
    step();
    pred_req = 1'b0;
    checks++;
    if ({pred_valid, pred_taken, pred_strong, pred_ctr} !== 5'b10001) begin
      errors++;
      $display("FAIL first_pred got %b want 10001", {pred_valid, pred_taken, pred_strong, pred_ctr});
    end
    step();
    checks++;
    if ({pred_valid, pred_ctr} !== 3'b001) begin
      errors++; $display("FAIL hold_no_req got %b want 001", {pred_valid, pred_ctr});
    end
  endtask

  task automatic test_saturate();
    logic [1:0] up_exp [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    logic [1:0] dn_exp [5] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      upd(4'd3, 1'b1, 1'b0);
      pred(4'd3);
      checks++;
      if (pred_ctr !== up_exp[i]) begin
        errors++; $display("FAIL sat_up[%0d] got %0d want %0d", i, pred_ctr, up_exp[i]);
      end
    end
    checks++;
    if ({pred_taken, pred_strong} !== 2'b11) begin
      errors++; $display("FAIL sat_max_flags got %b want 11", {pred_taken, pred_strong});
    end
    for (int i = 0; i < 5; i++) begin
      upd(4'd3, 1'b0, 1'b0);
      pred(4'd3);
      checks++;
      if (pred_ctr !== dn_exp[i]) begin
        errors++; $display("FAIL sat_dn[%0d] got %0d want %0d", i, pred_ctr, dn_exp[i]);
      end
    end
    checks++;
    if ({pred_taken, pred_strong} !== 2'b01) begin
      errors++; $display("FAIL sat_min_flags got %b want 01", {pred_taken, pred_strong});
    end
  endtask

  task automatic test_forward();
    pred_req = 1'b1; pred_idx = 4'd5;
    upd(4'd5, 1'b1, 1'b0);
    pred_req = 1'b0;
    checks++;
    if ({pred_valid, pred_taken, pred_strong, pred_ctr} !== 5'b11010) begin
      errors++;
      $display("FAIL fwd_same got %b want 11010", {pred_valid, pred_taken, pred_strong, pred_ctr});
    end
    pred_req = 1'b1; pred_idx = 4'd6;
    upd(4'd5, 1'b1, 1'b0);
    pred_req = 1'b0;
    checks++;
    if (pred_ctr !== 2'd1) begin
      errors++; $display("FAIL fwd_other got %0d want 1", pred_ctr);
    end
    pred(4'd5);
    checks++;
    if (pred_ctr !== 2'd3) begin
      errors++; $display("FAIL fwd_commit got %0d want 3", pred_ctr);
    end
  endtask

  task automatic test_back_to_back();
    upd_en = 1'b1; upd_idx = 4'd8; upd_taken = 1'b1;
    step();
    step();
    upd_en = 1'b0;
    pred(4'd8);
    checks++;
    if (pred_ctr !== 2'd3) begin
      errors++; $display("FAIL b2b_upd got %0d want 3", pred_ctr);
    end
    upd(4'd9, 1'b0, 1'b0);
    pred(4'd9);
    checks++;
    if ({pred_taken, pred_strong, pred_ctr} !== 4'b0100) begin
      errors++; $display("FAIL next_cycle_vis got %b want 0100", {pred_taken, pred_strong, pred_ctr});
    end
  endtask

  task automatic test_alloc();
    upd(4'd7, 1'b1, 1'b0);
    upd(4'd7, 1'b1, 1'b0);
    pred(4'd7);
    checks++;
    if (pred_ctr !== 2'd3) begin
      errors++; $display("FAIL alloc_pre got %0d want 3", pred_ctr);
    end
    upd(4'd7, 1'b1, 1'b1);
    pred(4'd7);
    checks++;
    if ({pred_taken, pred_strong, pred_ctr} !== 4'b0001) begin
      errors++; $display("FAIL alloc_wins got %b want 0001", {pred_taken, pred_strong, pred_ctr});
    end
  endtask

  task automatic test_reset_abort();
    int low;
    pred_req = 1'b1; pred_idx = 4'd7;
    step();
    pred_req = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({ready, pred_valid, pred_taken, pred_strong, pred_ctr} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got %b want 000000",
               {ready, pred_valid, pred_taken, pred_strong, pred_ctr});
    end
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    // Requests during the sweep must be ignored.
    upd_en = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1;
    pred_req = 1'b1; pred_idx = 4'd3;
    low = 0;
    for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
      if (pred_valid !== 1'b0) low = 100;
      low++;
      step();
    end
    upd_en = 1'b0; pred_req = 1'b0;
    checks++;
    if (low !== 16) begin
      errors++; $display("FAIL resweep_length got %0d want 16", low);
    end
    pred(4'd3);
    checks++;
    if (pred_ctr !== 2'd1) begin
      errors++; $display("FAIL resweep_idx3 got %0d want 1", pred_ctr);
    end
    pred(4'd8);
    checks++;
    if (pred_ctr !== 2'd1) begin
      errors++; $display("FAIL resweep_idx8 got %0d want 1", pred_ctr);
    end
  endtask

  task automatic test_ctr3();
    pred3(4'd2);
    checks++;
    if ({pred_valid3, pred_taken3, pred_strong3, pred_ctr3} !== 6'b100011) begin
      errors++;
      $display("FAIL w3_init got %b want 100011",
               {pred_valid3, pred_taken3, pred_strong3, pred_ctr3});
    end
    upd3(4'd2, 1'b1);
    pred3(4'd2);
    checks++;
    if ({pred_taken3, pred_strong3, pred_ctr3} !== 5'b10100) begin
      errors++; $display("FAIL w3_one got %b want 10100", {pred_taken3, pred_strong3, pred_ctr3});
    end
    for (int i = 0; i < 6; i++) upd3(4'd2, 1'b1);
    pred3(4'd2);
    checks++;
    if ({pred_taken3, pred_strong3, pred_ctr3} !== 5'b11111) begin
      errors++; $display("FAIL w3_sat got %b want 11111", {pred_taken3, pred_strong3, pred_ctr3});
    end
    upd3(4'd2, 1'b0);
    pred3(4'd2);
    checks++;
    if (pred_ctr3 !== 3'd6) begin
      errors++; $display("FAIL w3_dec got %0d want 6", pred_ctr3);
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_forward();
    test_back_to_back();
    test_alloc();
    test_reset_abort();
    test_ctr3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bht_param.md
Name: bht_param

Overview:
- Parametrised bimodal prediction table for the TAGE base predictor.
- Saturating counters with configurable width and depth.
- Decoupled predict (read) and update (write) ports, same-cycle update forwarding, explicit allocate/reinit writes.
- A post-reset init sequencer clears the array one entry per cycle, so the storage needs no reset fan-out and maps to RAM.

Parameters:
IDX_W, 10, index width; DEPTH = 2**IDX_W entries
CTR_W, 2, counter width in bits (legal 2..4)
INIT_VAL, 2**(CTR_W-1)-1, value written at init and on allocate (weakly not-taken)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous, active-low reset
ready_o  out  1  table initialised; requests accepted
pred_req_i  in  1  predict request this cycle
pred_idx_i  in  IDX_W  predict index
pred_valid_o  out  1  prediction outputs valid (1 cycle after accepted request)
pred_taken_o  out  1  counter MSB
pred_strong_o  out  1  counter is 0 or 2**CTR_W-1
pred_ctr_o  out  CTR_W  raw counter value
upd_en_i  in  1  train entry upd_idx_i with upd_taken_i
upd_alloc_i  in  1  overwrite entry upd_idx_i with INIT_VAL
upd_idx_i  in  IDX_W  update index
upd_taken_i  in  1  resolved branch outcome

Behaviour:
- Reset (rst_ni=0, async) forces state INIT, init_ptr=0, ready_o=0, pred_valid_o=0, pred_taken_o=0, pred_strong_o=0, pred_ctr_o=0. Array contents are not reset directly.
- Reset asserted mid-INIT or mid-READY aborts the current operation. After release the sweep restarts from index 0.
- FSM INIT: each cycle writes INIT_VAL to entry init_ptr, then init_ptr++.
  - After the write of DEPTH-1, go to READY. ready_o=1 from the next cycle.
  - INIT lasts exactly DEPTH cycles after reset release.
  - pred_req_i, upd_en_i and upd_alloc_i are ignored in INIT; pred_valid_o stays 0.
- FSM READY: terminal until reset.
- Predict:
  - Accepted when READY and pred_req_i.
  - Outputs are registered with 1-cycle latency.
  - pred_valid_o = registered acceptance.
  - Output registers hold their last values when there is no request; only pred_valid_o drops.
- Update (READY only):
  - upd_alloc_i has priority over upd_en_i: entry := INIT_VAL.
  - upd_en_i alone, upd_taken_i=1: entry := min(entry+1, 2**CTR_W-1).
  - upd_en_i alone, upd_taken_i=0: entry := max(entry-1, 0).
  - No wrap-around at 0 or max.
  - The write commits at the rising edge.
- Forwarding:
  - If an update is effective and pred_idx_i==upd_idx_i in the same cycle, the prediction registered is the post-update value.
  - Updates to other indices have no effect on the prediction.
  - An update in cycle N is visible to any predict in cycle N+1 and later.
- Back-to-back updates to the same index in consecutive cycles each apply. There is no lost-update window and no prev-index gating.
- Arithmetic is done at CTR_W+1 bits internally and then clamped. pred_strong_o is computed from the final (forwarded) value.

Decomposition:
- Shared package tage_pkg holds:
  - BHT_IDX_W and BHT_CTR_W defaults.
  - typedef bht_ctr_t (logic [CTR_W-1:0]).
  - typedef enum bht_state_e {BHT_INIT, BHT_READY}.
  - Function sat_ctr_next(ctr, taken) returning the clamped next value, reused by TAGE tagged tables.
- One sub-module, bht_init_seq: owns the FSM and init_ptr; outputs init_we, init_idx, ready.
- The table array, update/forward mux and output registers live in bht_param.

Test Plan:
1. IDX_W=4, CTR_W=2: release reset, hold pred_req_i=1 idx=0. Expect ready_o=0 for 16 cycles, then ready_o=1. First pred_valid_o=1 one cycle after ready, with pred_ctr_o=1, taken=0, strong=0.
2. Four upd_en taken=1 on idx 3, then predict idx 3. Expect ctr 1→2→3→3→3, pred_ctr_o=3, taken=1, strong=1 (saturates, no wrap). Then five taken=0 updates: expect pred_ctr_o=0, strong=1.
3. Same cycle: upd_en taken=1 on idx 5 (ctr=1) and pred_req idx 5. Expect next cycle pred_ctr_o=2, taken=1 (forwarded). Repeat with pred idx 6: expect pred_ctr_o=1.
4. Drive idx 7 to 3, then assert upd_alloc_i=1 together with upd_en_i=1, taken=1, on idx 7. Expect pred_ctr_o=1 (alloc wins).
5. Assert rst_ni=0 for 1 cycle after 8 init cycles. Expect ready_o=0 immediately (async) and a full 16-cycle re-sweep. Entries trained earlier read back as 1.
6. CTR_W=3 build: from INIT_VAL=3, one taken update gives ctr=4, taken=1, strong=0. Seven taken updates give ctr=7, strong=1.
